// File: rtl/tick_interval_meter.sv
// tick_interval_meter
//   Receiving end of a free-running tick generator. Measures the number of clk
//   cycles between successive rising edges of tic_in and hands each measured
//   period to a consumer over a valid/ready port. Sticky flags report lost
//   ticks (timeout), results dropped under backpressure (overrun) and, when
//   enabled, edges rejected as glitches.
//
//   Build option: define TIM_GLITCH_REJECT_EN to ignore edges that arrive less
//   than MIN_PERIOD cycles after the previous one. Without it every edge is
//   measured and glitch_o is tied low.
module tick_interval_meter #(
  parameter int W          = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tic_in,
  input  logic         clr,
  output logic [W-1:0] period_o,
  output logic         period_valid_o,
  input  logic         period_ready_i,
  output logic         locked_o,
  output logic         timeout_o,
  output logic         overrun_o,
  output logic         glitch_o
);

  // The counter saturates here; reaching it means a tick went missing.
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t       state_reg;
  state_t       state_next;
  logic         tic_q_reg;
  logic         tic_edge;
  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;
  logic [W-1:0] period_meas;
  logic         capture;
  logic         timeout_hit;
  logic         too_short;

  logic [W-1:0] period_reg;
  logic [W-1:0] period_next;
  logic         valid_reg;
  logic         valid_next;
  logic         locked_reg;
  logic         locked_next;
  logic         timeout_reg;
  logic         timeout_next;
  logic         overrun_reg;
  logic         overrun_next;

  // A rising edge is seen in the very cycle tic_in first reads high, so a
  // level held for several cycles only counts once.
  assign tic_edge = tic_in & ~tic_q_reg;

  // The measured period is the cycle distance between the two edges: cnt is
  // zero in the cycle after the first edge, hence the +1.
  assign period_meas = cnt_reg + 1'b1;

`ifdef TIM_GLITCH_REJECT_EN
  localparam logic [W:0] MIN_P = (W+1)'(MIN_PERIOD);

  logic [W:0] cnt_plus1;
  logic       glitch_hit;
  logic       glitch_reg;
  logic       glitch_next;

  // Compare one bit wider so the +1 can never wrap.
  assign cnt_plus1 = {1'b0, cnt_reg} + {{W{1'b0}}, 1'b1};
  assign too_short = (cnt_plus1 < MIN_P);
`else
  logic unused_min_period;

  assign too_short         = 1'b0;
  assign unused_min_period = (MIN_PERIOD != 0);
`endif

  // Registered copy of the tick for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tic_q_reg <= 1'b0;
    end else if (clr) begin
      tic_q_reg <= 1'b0;
    end else begin
      tic_q_reg <= tic_in;
    end
  end

  // Measurement state and interval counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else if (clr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: start on the first edge, capture on later edges, and
  // fall back on timeout when the counter saturates.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    capture     = 1'b0;
    timeout_hit = 1'b0;
`ifdef TIM_GLITCH_REJECT_EN
    glitch_hit  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (tic_edge) begin
          state_next = MEASURE;
          cnt_next   = '0;
        end
      end
      MEASURE: begin
        if (cnt_reg == CNT_MAX) begin
          // Saturated: the interval is too long to measure. An edge landing
          // on this cycle becomes the first edge of a fresh measurement.
          timeout_hit = 1'b1;
          cnt_next    = '0;
          state_next  = tic_edge ? MEASURE : IDLE;
        end else if (tic_edge) begin
          if (too_short) begin
            // Rejected edge: keep counting from the previous accepted edge.
            cnt_next = cnt_reg + 1'b1;
`ifdef TIM_GLITCH_REJECT_EN
            glitch_hit = 1'b1;
`endif
          end else begin
            capture  = 1'b1;
            cnt_next = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output handshake and status flags: a capture loads when the slot is free
  // or being drained this cycle, otherwise it is dropped and flagged.
  always_comb begin
    period_next  = period_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    locked_next  = locked_reg;
    timeout_next = timeout_reg | timeout_hit;
    if (capture) begin
      locked_next = 1'b1;
      if (!valid_reg || period_ready_i) begin
        period_next = period_meas;
        valid_next  = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (valid_reg && period_ready_i) begin
      valid_next = 1'b0;
    end
    if (timeout_hit) begin
      locked_next = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_reg  <= '0;
      valid_reg   <= 1'b0;
      locked_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (clr) begin
      period_reg  <= '0;
      valid_reg   <= 1'b0;
      locked_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      period_reg  <= period_next;
      valid_reg   <= valid_next;
      locked_reg  <= locked_next;
      timeout_reg <= timeout_next;
      overrun_reg <= overrun_next;
    end
  end

`ifdef TIM_GLITCH_REJECT_EN
  assign glitch_next = glitch_reg | glitch_hit;

  // Sticky glitch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_reg <= 1'b0;
    end else if (clr) begin
      glitch_reg <= 1'b0;
    end else begin
      glitch_reg <= glitch_next;
    end
  end

  assign glitch_o = glitch_reg;
`else
  assign glitch_o = 1'b0;
`endif

  assign period_o       = period_reg;
  assign period_valid_o = valid_reg;
  assign locked_o       = locked_reg;
  assign timeout_o      = timeout_reg;
  assign overrun_o      = overrun_reg;

endmodule

// File: tb/tb_tick_interval_meter.sv
// Directed bench for tick_interval_meter (W=8, MIN_PERIOD=3). Observed status
// is packed as {period, valid, locked, timeout, overrun, glitch}.
module tb_tick_interval_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tic_in = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] period_o;
  logic       period_valid_o;
  logic       period_ready_i = 1'b0;
  logic       locked_o;
  logic       timeout_o;
  logic       overrun_o;
  logic       glitch_o;

  int         vectors = 0;
  int         miscompares = 0;
  int         xfer_cnt = 0;
  logic [7:0] xfer_last = '0;
  logic [12:0] status;

  tick_interval_meter #(.W(8), .MIN_PERIOD(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tic_in         (tic_in),
    .clr            (clr),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .period_ready_i (period_ready_i),
    .locked_o       (locked_o),
    .timeout_o      (timeout_o),
    .overrun_o      (overrun_o),
    .glitch_o       (glitch_o)
  );

  always #5 clk = ~clk;

  assign status = {period_o, period_valid_o, locked_o, timeout_o, overrun_o, glitch_o};

  function automatic logic [12:0] pack(input int p, input bit v, input bit l,
                                       input bit t, input bit o, input bit g);
    logic [7:0] pv;
    pv = p[7:0];
    return {pv, v, l, t, o, g};
  endfunction

  // One clock cycle with the given tick level; logs a transfer if one occurs.
  task automatic step(input logic tic);
    tic_in = tic;
    if (period_valid_o === 1'b1 && period_ready_i === 1'b1) begin
      xfer_cnt++;
      xfer_last = period_o;
      $display("[%0t] transfer period=%0d", $time, period_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    tic_in = 1'b0;
    clr = 1'b0;
    period_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfer_cnt = 0;
    xfer_last = '0;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (status !== pack(0,0,0,0,0,0)) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", status, pack(0,0,0,0,0,0));
    end
    tic_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (status !== pack(0,0,0,0,0,0)) begin
      miscompares++;
      $display("FAIL reset_held: got %h expected %h", status, pack(0,0,0,0,0,0));
    end
    tic_in = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_steady();
    do_reset();
    period_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(c % 4 == 0 && c <= 16);
      if (c == 3) begin
        vectors++;
        if (status !== pack(0,0,0,0,0,0)) begin
          miscompares++;
          $display("FAIL steady_c3: got %h expected %h", status, pack(0,0,0,0,0,0));
        end
      end
      if (c == 4) begin
        vectors++;
        if (status !== pack(4,1,1,0,0,0)) begin
          miscompares++;
          $display("FAIL steady_c4: got %h expected %h", status, pack(4,1,1,0,0,0));
        end
      end
      if (c == 5) begin
        vectors++;
        if (status !== pack(4,0,1,0,0,0)) begin
          miscompares++;
          $display("FAIL steady_c5: got %h expected %h", status, pack(4,0,1,0,0,0));
        end
      end
    end
    vectors++;
    if (xfer_cnt !== 4 || xfer_last !== 8'd4) begin
      miscompares++;
      $display("FAIL steady_xfers: got count=%0d last=%0d expected count=4 last=4", xfer_cnt, xfer_last);
    end
    vectors++;
    if (status !== pack(4,0,1,0,0,0)) begin
      miscompares++;
      $display("FAIL steady_end: got %h expected %h", status, pack(4,0,1,0,0,0));
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      step(c == 0 || c == 5 || c == 12);
      if (c == 5) begin
        vectors++;
        if (status !== pack(5,1,1,0,0,0)) begin
          miscompares++;
          $display("FAIL overrun_c5: got %h expected %h", status, pack(5,1,1,0,0,0));
        end
      end
      if (c == 12) begin
        vectors++;
        if (status !== pack(5,1,1,0,1,0)) begin
          miscompares++;
          $display("FAIL overrun_c12: got %h expected %h", status, pack(5,1,1,0,1,0));
        end
      end
    end
    period_ready_i = 1'b1;
    step(1'b0);
    period_ready_i = 1'b0;
    vectors++;
    if (xfer_cnt !== 1 || xfer_last !== 8'd5) begin
      miscompares++;
      $display("FAIL overrun_xfer: got count=%0d last=%0d expected count=1 last=5", xfer_cnt, xfer_last);
    end
    step(1'b0);
    vectors++;
    if (status !== pack(5,0,1,0,1,0)) begin
      miscompares++;
      $display("FAIL overrun_drained: got %h expected %h", status, pack(5,0,1,0,1,0));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      period_ready_i = (c >= 9);
      step(c == 0 || c == 3 || c == 9);
      if (c == 3) begin
        vectors++;
        if (status !== pack(3,1,1,0,0,0)) begin
          miscompares++;
          $display("FAIL b2b_c3: got %h expected %h", status, pack(3,1,1,0,0,0));
        end
      end
      if (c == 9) begin
        vectors++;
        if (status !== pack(6,1,1,0,0,0) || xfer_cnt !== 1 || xfer_last !== 8'd3) begin
          miscompares++;
          $display("FAIL b2b_c9: got %h xfers=%0d last=%0d expected %h xfers=1 last=3",
                   status, xfer_cnt, xfer_last, pack(6,1,1,0,0,0));
        end
      end
    end
    vectors++;
    if (status !== pack(6,0,1,0,0,0) || xfer_cnt !== 2 || xfer_last !== 8'd6) begin
      miscompares++;
      $display("FAIL b2b_end: got %h xfers=%0d last=%0d expected %h xfers=2 last=6",
               status, xfer_cnt, xfer_last, pack(6,0,1,0,0,0));
    end
  endtask

  task automatic test_held_high();
    do_reset();
    period_ready_i = 1'b1;
    for (int c = 0; c < 62; c++) begin
      step((c % 20) < 6);
      if (c == 20) begin
        vectors++;
        if (status !== pack(20,1,1,0,0,0)) begin
          miscompares++;
          $display("FAIL held_c20: got %h expected %h", status, pack(20,1,1,0,0,0));
        end
      end
      if (c == 25) begin
        vectors++;
        if (status !== pack(20,0,1,0,0,0)) begin
          miscompares++;
          $display("FAIL held_c25: got %h expected %h", status, pack(20,0,1,0,0,0));
        end
      end
    end
    vectors++;
    if (xfer_cnt !== 3 || xfer_last !== 8'd20) begin
      miscompares++;
      $display("FAIL held_xfers: got count=%0d last=%0d expected count=3 last=20", xfer_cnt, xfer_last);
    end
  endtask

  task automatic test_max_period();
    do_reset();
    for (int c = 0; c < 256; c++) begin
      step(c == 0 || c == 255);
    end
    vectors++;
    if (status !== pack(255,1,1,0,0,0)) begin
      miscompares++;
      $display("FAIL max_period: got %h expected %h", status, pack(255,1,1,0,0,0));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    period_ready_i = 1'b1;
    for (int c = 0; c < 281; c++) begin
      step(c == 0 || c == 7 || c == 270 || c == 280);
      if (c == 262) begin
        vectors++;
        if (status !== pack(7,0,1,0,0,0)) begin
          miscompares++;
          $display("FAIL timeout_c262: got %h expected %h", status, pack(7,0,1,0,0,0));
        end
      end
      if (c == 263) begin
        vectors++;
        if (status !== pack(7,0,0,1,0,0)) begin
          miscompares++;
          $display("FAIL timeout_c263: got %h expected %h", status, pack(7,0,0,1,0,0));
        end
      end
      if (c == 270) begin
        vectors++;
        if (status !== pack(7,0,0,1,0,0)) begin
          miscompares++;
          $display("FAIL timeout_first_edge: got %h expected %h", status, pack(7,0,0,1,0,0));
        end
      end
    end
    vectors++;
    if (status !== pack(10,1,1,1,0,0)) begin
      miscompares++;
      $display("FAIL timeout_relock: got %h expected %h", status, pack(10,1,1,1,0,0));
    end
  endtask

  task automatic test_timeout_edge();
    do_reset();
    period_ready_i = 1'b1;
    for (int c = 0; c < 274; c++) begin
      step(c == 0 || c == 7 || c == 263 || c == 273);
      if (c == 263) begin
        vectors++;
        if (status !== pack(7,0,0,1,0,0)) begin
          miscompares++;
          $display("FAIL tmo_edge_c263: got %h expected %h", status, pack(7,0,0,1,0,0));
        end
      end
    end
    vectors++;
    if (status !== pack(10,1,1,1,0,0)) begin
      miscompares++;
      $display("FAIL tmo_edge_restart: got %h expected %h", status, pack(10,1,1,1,0,0));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      step(c == 0 || c == 10);
    end
    vectors++;
    if (status !== pack(10,1,1,0,0,0)) begin
      miscompares++;
      $display("FAIL arst_before: got %h expected %h", status, pack(10,1,1,0,0,0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (status !== pack(0,0,0,0,0,0)) begin
      miscompares++;
      $display("FAIL arst_immediate: got %h expected %h", status, pack(0,0,0,0,0,0));
    end
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(c == 0 || c == 7);
      if (c == 0) begin
        vectors++;
        if (status !== pack(0,0,0,0,0,0)) begin
          miscompares++;
          $display("FAIL arst_first_edge: got %h expected %h", status, pack(0,0,0,0,0,0));
        end
      end
    end
    vectors++;
    if (status !== pack(7,1,1,0,0,0)) begin
      miscompares++;
      $display("FAIL arst_second_edge: got %h expected %h", status, pack(7,1,1,0,0,0));
    end
  endtask

  task automatic test_clr();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(c == 0 || c == 6 || c == 9);
    end
    vectors++;
    if (status !== pack(6,1,1,0,1,0)) begin
      miscompares++;
      $display("FAIL clr_before: got %h expected %h", status, pack(6,1,1,0,1,0));
    end
    clr = 1'b1;
    step(1'b0);
    clr = 1'b0;
    vectors++;
    if (status !== pack(0,0,0,0,0,0)) begin
      miscompares++;
      $display("FAIL clr_applied: got %h expected %h", status, pack(0,0,0,0,0,0));
    end
    for (int c = 0; c < 10; c++) begin
      step(c == 0 || c == 9);
    end
    vectors++;
    if (status !== pack(9,1,1,0,0,0)) begin
      miscompares++;
      $display("FAIL clr_after: got %h expected %h", status, pack(9,1,1,0,0,0));
    end
  endtask

  task automatic test_glitch();
    logic [12:0] exp_c2;
    logic [12:0] exp_c8;
`ifdef TIM_GLITCH_REJECT_EN
    exp_c2 = pack(0,0,0,0,0,1);
    exp_c8 = pack(8,1,1,0,0,1);
`else
    exp_c2 = pack(2,1,1,0,0,0);
    exp_c8 = pack(2,1,1,0,1,0);
`endif
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(c == 0 || c == 2 || c == 8);
      if (c == 2) begin
        vectors++;
        if (status !== exp_c2) begin
          miscompares++;
          $display("FAIL glitch_c2: got %h expected %h", status, exp_c2);
        end
      end
    end
    vectors++;
    if (status !== exp_c8) begin
      miscompares++;
      $display("FAIL glitch_c8: got %h expected %h", status, exp_c8);
    end
    // An edge exactly MIN_PERIOD cycles later is always accepted.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(c == 0 || c == 3);
    end
    vectors++;
    if (status !== pack(3,1,1,0,0,0)) begin
      miscompares++;
      $display("FAIL glitch_min_ok: got %h expected %h", status, pack(3,1,1,0,0,0));
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_overrun();
    test_back_to_back();
    test_held_high();
    test_max_period();
    test_timeout();
    test_timeout_edge();
    test_async_reset();
    test_clr();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
